// File: rtl/shift64_ctrl_if.sv
// Bundles the shift64_ctrl control handshake, operands, results and
// time-shared barrel-shifter bus into one interface.
interface shift64_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    logic          start;
    logic [1:0]    op;
    logic [AW-1:0] amt;
    logic [DW-1:0] din_hi;
    logic [DW-1:0] din_lo;
    logic [DW-1:0] bs_D;
    logic [4:0]    bs_shamt;
    logic [1:0]    bs_LRRA;
    logic [DW-1:0] bs_Y;
    logic [DW-1:0] dout_hi;
    logic [DW-1:0] dout_lo;
    logic          carry;
    logic          err;
    logic          busy;
    logic          done;

    modport master (
        output start, op, amt, din_hi, din_lo, bs_Y,
        input  bs_D, bs_shamt, bs_LRRA, dout_hi, dout_lo, carry, err, busy, done
    );

    modport slave (
        input  start, op, amt, din_hi, din_lo, bs_Y,
        output bs_D, bs_shamt, bs_LRRA, dout_hi, dout_lo, carry, err, busy, done
    );
endinterface

// File: rtl/shift64_ctrl.sv
// 64-bit SLL/SRL/SRA sequencer built on one shared 32-bit barrel shifter.
// Optional ROR64 (op=11) is enabled by defining SHIFT64_ROTATE_EN.
module shift64_ctrl #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input logic           clk,
    input logic           reset,
    shift64_ctrl_if.slave bus
);
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;
    localparam logic [1:0] BS_SLL = 2'b00;
    localparam logic [1:0] BS_SRL = 2'b01;
    localparam logic [1:0] BS_SRA = 2'b10;
    localparam logic [1:0] BS_OFF = 2'b11;

    typedef enum logic [2:0] {IDLE, OP_A, OP_B, OP_C, OP_D, DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] op_hi, op_lo, hi_w, lo_w, hi_nx, lo_nx;
    logic [DW-1:0] dout_hi_q, dout_lo_q;
    logic [1:0]    op_r;
    logic [AW-1:0] amt_r;
    logic          carry_w, carry_nx, carry_q, err_q;
    logic          accept, commit, illegal, rot_swap;
    logic [5:0]    cidx;
    logic [2*DW-1:0] wide;
    logic [4:0]    m, neg_m;

    // m is n for n<32 and n-32 for n>32; neg_m is 32-n, never 0 when m is not
    assign m     = amt_r[4:0];
    assign neg_m = 5'd0 - amt_r[4:0];
    assign wide  = {bus.din_hi, bus.din_lo};

    always_comb begin
        state_d      = state_q;
        hi_nx        = hi_w;
        lo_nx        = lo_w;
        carry_nx     = carry_w;
        accept       = 1'b0;
        commit       = 1'b0;
        illegal      = 1'b0;
        rot_swap     = 1'b0;
        cidx         = 6'd0;
        bus.bs_D     = '0;
        bus.bs_shamt = 5'd0;
        bus.bs_LRRA  = BS_OFF;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
`ifdef SHIFT64_ROTATE_EN
                    rot_swap = (bus.op == OP_ROR) && (bus.amt > AW'(32));
`else
                    illegal = (bus.op == OP_ROR);
`endif
                    cidx     = (bus.op == OP_SLL) ? 6'd0 - bus.amt : bus.amt - 6'd1;
                    carry_nx = (bus.amt == '0) ? 1'b0 : wide[cidx];
                    if (illegal) begin
                        state_d = DONE;
                    end else if (bus.amt == '0) begin
                        hi_nx   = bus.din_hi;
                        lo_nx   = bus.din_lo;
                        commit  = 1'b1;
                        state_d = DONE;
                    end else if (bus.amt == AW'(32)) begin
                        case (bus.op)
                            OP_SLL:  begin hi_nx = bus.din_lo; lo_nx = '0; end
                            OP_SRL:  begin hi_nx = '0; lo_nx = bus.din_hi; end
                            OP_SRA:  begin hi_nx = {DW{bus.din_hi[DW-1]}}; lo_nx = bus.din_hi; end
                            default: begin hi_nx = bus.din_lo; lo_nx = bus.din_hi; end
                        endcase
                        commit  = 1'b1;
                        state_d = DONE;
                    end else if (bus.amt > AW'(32) && bus.op != OP_ROR) begin
                        // Only the word fed by the shifter is left for OP_C
                        case (bus.op)
                            OP_SLL:  lo_nx = '0;
                            OP_SRA:  hi_nx = {DW{bus.din_hi[DW-1]}};
                            default: hi_nx = '0;
                        endcase
                        state_d = OP_C;
                    end else begin
                        state_d = OP_A;
                    end
                end
            end
            OP_A: begin
                bus.bs_shamt = m;
                if (op_r == OP_SLL) begin
                    bus.bs_D = op_hi; bus.bs_LRRA = BS_SLL; hi_nx = bus.bs_Y;
                end else begin
                    bus.bs_D = op_lo; bus.bs_LRRA = BS_SRL; lo_nx = bus.bs_Y;
                end
                state_d = OP_B;
            end
            OP_B: begin
                bus.bs_shamt = neg_m;
                if (op_r == OP_SLL) begin
                    bus.bs_D = op_lo; bus.bs_LRRA = BS_SRL; hi_nx = hi_w | bus.bs_Y;
                end else begin
                    bus.bs_D = op_hi; bus.bs_LRRA = BS_SLL; lo_nx = lo_w | bus.bs_Y;
                end
                state_d = OP_C;
            end
            OP_C: begin
                bus.bs_shamt = m;
                if (op_r == OP_SLL) begin
                    bus.bs_D = op_lo; bus.bs_LRRA = BS_SLL;
                    if (amt_r > AW'(32)) hi_nx = bus.bs_Y;
                    else                 lo_nx = bus.bs_Y;
                end else begin
                    bus.bs_D    = op_hi;
                    bus.bs_LRRA = (op_r == OP_SRA) ? BS_SRA : BS_SRL;
                    if (amt_r > AW'(32) && op_r != OP_ROR) lo_nx = bus.bs_Y;
                    else                                   hi_nx = bus.bs_Y;
                end
`ifdef SHIFT64_ROTATE_EN
                if (op_r == OP_ROR) begin
                    state_d = OP_D;
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
`else
                commit  = 1'b1;
                state_d = DONE;
`endif
            end
`ifdef SHIFT64_ROTATE_EN
            OP_D: begin
                bus.bs_shamt = neg_m;
                bus.bs_D     = op_lo;
                bus.bs_LRRA  = BS_SLL;
                hi_nx        = hi_w | bus.bs_Y;
                commit       = 1'b1;
                state_d      = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_hi     <= '0;
            op_lo     <= '0;
            hi_w      <= '0;
            lo_w      <= '0;
            carry_w   <= 1'b0;
            op_r      <= '0;
            amt_r     <= '0;
            dout_hi_q <= '0;
            dout_lo_q <= '0;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_w    <= hi_nx;
            lo_w    <= lo_nx;
            carry_w <= carry_nx;
            if (accept) begin
                // ROR by n>32 is a word swap followed by ROR by n-32
                op_hi <= rot_swap ? bus.din_lo : bus.din_hi;
                op_lo <= rot_swap ? bus.din_hi : bus.din_lo;
                op_r  <= bus.op;
                amt_r <= bus.amt;
                err_q <= illegal;
            end
            if (commit) begin
                dout_hi_q <= hi_nx;
                dout_lo_q <= lo_nx;
                carry_q   <= carry_nx;
            end
        end
    end

    assign bus.dout_hi = dout_hi_q;
    assign bus.dout_lo = dout_lo_q;
    assign bus.carry   = carry_q;
    assign bus.err     = err_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
endmodule

// File: tb/tb_shift64_ctrl.sv
// Directed bench for shift64_ctrl with a behavioural 32-bit barrel shifter
// answering the controller's shifter bus.
module tb_shift64_ctrl;
    localparam int DW = 32;
    localparam int AW = 6;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  amt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_c;
        int          exp_k;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] prev_hi = '0, prev_lo = '0;
    logic        prev_c = 1'b0;
    vec_t vecs[12];

    shift64_ctrl_if #(.DW(DW), .AW(AW)) bus ();
    shift64_ctrl #(.DW(DW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always_comb begin
        case (bus.bs_LRRA)
            2'b00:   bus.bs_Y = bus.bs_D << bus.bs_shamt;
            2'b01:   bus.bs_Y = bus.bs_D >> bus.bs_shamt;
            2'b10:   bus.bs_Y = $unsigned($signed(bus.bs_D) >>> bus.bs_shamt);
            default: bus.bs_Y = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Shifter must be active with a nonzero amount in OP states, inert elsewhere
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.busy && !bus.done) chk("shamt_nonzero", 32'(bus.bs_shamt != 5'd0), 32'd1);
            else                       chk("lrra_inert", 32'(bus.bs_LRRA), 32'd3);
        end
    end

    task automatic run(input logic [1:0] op, input logic [5:0] amt, input logic [31:0] hi,
                       input logic [31:0] lo, output int k);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.amt = amt; bus.din_hi = hi; bus.din_lo = lo;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 1;
        if (bus.done !== 1'b1) begin
            chk("hold_hi", bus.dout_hi, prev_hi);
            chk("hold_lo", bus.dout_lo, prev_lo);
        end
        while (bus.done !== 1'b1 && k < 12) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic check_result(input string tag, input int k, input int exp_k,
                                input logic [31:0] eh, input logic [31:0] el, input logic ec);
        chk({tag, "_k"}, 32'(k), 32'(exp_k));
        chk({tag, "_hi"}, bus.dout_hi, eh);
        chk({tag, "_lo"}, bus.dout_lo, el);
        chk({tag, "_carry"}, 32'(bus.carry), 32'(ec));
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        prev_hi = eh; prev_lo = el; prev_c = ec;
        @(posedge clk); #1;
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int  k;
        logic seen_done;
        vecs[0]  = '{2'b00, 6'd1,  32'h00000001, 32'h80000000, 32'h00000003, 32'h00000000, 1'b0, 4};
        vecs[1]  = '{2'b10, 6'd40, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'hFF800000, 1'b0, 2};
        vecs[2]  = '{2'b01, 6'd32, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h12345678, 1'b1, 1};
        vecs[3]  = '{2'b01, 6'd0,  32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1};
        vecs[4]  = '{2'b00, 6'd4,  32'h12345678, 32'h9ABCDEF0, 32'h23456789, 32'hABCDEF00, 1'b1, 4};
        vecs[5]  = '{2'b01, 6'd4,  32'h12345678, 32'h9ABCDEF0, 32'h01234567, 32'h89ABCDEF, 1'b0, 4};
        vecs[6]  = '{2'b10, 6'd8,  32'h87654321, 32'h0FEDCBA9, 32'hFF876543, 32'h210FEDCB, 1'b1, 4};
        vecs[7]  = '{2'b00, 6'd33, 32'h00000000, 32'hC0000001, 32'h80000002, 32'h00000000, 1'b1, 2};
        vecs[8]  = '{2'b01, 6'd63, 32'hF0000000, 32'h00000001, 32'h00000000, 32'h00000001, 1'b1, 2};
        vecs[9]  = '{2'b10, 6'd32, 32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1};
        vecs[10] = '{2'b00, 6'd31, 32'hAAAAAAAA, 32'h55555555, 32'h2AAAAAAA, 32'h80000000, 1'b1, 4};
        vecs[11] = '{2'b10, 6'd1,  32'h80000001, 32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 4};

        bus.start = 1'b0; bus.op = '0; bus.amt = '0; bus.din_hi = '0; bus.din_lo = '0;
        @(negedge clk);
        chk("rst_hi", bus.dout_hi, 32'd0);
        chk("rst_lo", bus.dout_lo, 32'd0);
        chk("rst_flags", 32'({bus.carry, bus.err, bus.busy, bus.done}), 32'd0);
        chk("rst_lrra", 32'(bus.bs_LRRA), 32'd3);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run(vecs[i].op, vecs[i].amt, vecs[i].hi, vecs[i].lo, k);
            check_result($sformatf("vec%0d", i), k, vecs[i].exp_k,
                         vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_c);
        end

        // start held through the DONE cycle must not launch a new operation
        run(2'b00, 6'd0, 32'hDEADBEEF, 32'h0BADF00D, k);
        bus.start = 1'b1; bus.amt = 6'd1;
        chk("dstart_k", 32'(k), 32'd1);
        chk("dstart_hi", bus.dout_hi, 32'hDEADBEEF);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("dstart_ignored", 32'(bus.busy), 32'd0);
        prev_hi = 32'hDEADBEEF; prev_lo = 32'h0BADF00D; prev_c = 1'b0;

`ifdef SHIFT64_ROTATE_EN
        run(2'b11, 6'd4, 32'h00000001, 32'h00000000, k);
        check_result("ror4", k, 5, 32'h00000000, 32'h10000000, 1'b0);
        run(2'b11, 6'd36, 32'h00000001, 32'h00000000, k);
        check_result("ror36", k, 5, 32'h10000000, 32'h00000000, 1'b0);
`else
        run(2'b11, 6'd4, 32'h00000001, 32'h00000000, k);
        chk("ror_k", 32'(k), 32'd1);
        chk("ror_err", 32'(bus.err), 32'd1);
        chk("ror_hi", bus.dout_hi, prev_hi);
        chk("ror_lo", bus.dout_lo, prev_lo);
        chk("ror_carry", 32'(bus.carry), 32'(prev_c));
        @(posedge clk); #1;
`endif
        // next accepted start clears err
        run(2'b01, 6'd8, 32'h00000100, 32'h00000000, k);
        check_result("errclr", k, 4, 32'h00000001, 32'h00000000, 1'b0);

        // start during OP_B ignored, then reset in OP_C aborts
        run(2'b00, 6'd1, 32'h0000F00D, 32'h80000000, k);
        check_result("pre_abort", k, 4, 32'h0001E01B, 32'h00000000, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.amt = 6'd1; bus.din_hi = 32'h1; bus.din_lo = 32'h0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.amt = 6'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_start_done", 32'(bus.done), 32'd0);
        chk("busy_start_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_hi", bus.dout_hi, 32'd0);
        chk("abort_lo", bus.dout_lo, 32'd0);
        chk("abort_flags", 32'({bus.carry, bus.err, bus.busy, bus.done}), 32'd0);
        chk("abort_lrra", 32'(bus.bs_LRRA), 32'd3);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
